// File: rtl/ysyx_22040750_clint.sv
// Core-local interruptor: mtime / mtimecmp / msip behind a single-outstanding valid/ready port.
// Raises O_mtip from a registered mtime >= mtimecmp compare and O_msip from msip[0].
module ysyx_22040750_clint #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        I_sys_clk,
   input  logic        I_rst,
   input  logic        I_req_valid,
   output logic        O_req_ready,
   input  logic        I_req_wen,
   input  logic [31:0] I_req_addr,
   input  logic [63:0] I_req_wdata,
   input  logic [7:0]  I_req_wmask,
   output logic        O_resp_valid,
   input  logic        I_resp_ready,
   output logic [63:0] O_resp_rdata,
   output logic        O_resp_err,
   output logic        O_hit,
   output logic        O_mtip,
   output logic        O_msip
);

   // state  | meaning
   // S_IDLE | ready for a request
   // S_RESP | response held until I_resp_ready

   localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [15:0]    OFF_MSIP   = 16'h0000;
   localparam logic [15:0]    OFF_CMP    = 16'h4000;
   localparam logic [15:0]    OFF_MTIME  = 16'hBFF8;

   typedef enum logic {S_IDLE, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic [63:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          mtip_q;
   logic          msip_out_q;

   logic          tick;
   logic          accept;
   logic          sel_msip, sel_cmp, sel_mtime, mapped;
   logic [63:0]   mtime_inc;
   logic [63:0]   bytemask;

   assign O_hit        = (I_req_addr[31:16] == BASE_ADDR[31:16]);
   assign O_req_ready  = (state_q == S_IDLE);
   assign O_resp_valid = (state_q == S_RESP);
   assign O_resp_rdata = rdata_q;
   assign O_resp_err   = err_q;
   assign O_mtip       = mtip_q;
   assign O_msip       = msip_out_q;

   assign accept    = I_req_valid & O_req_ready & O_hit;
   assign tick      = (presc_q == PRESC_LAST);
   assign mtime_inc = mtime_q + {63'd0, tick};
   assign sel_msip  = (I_req_addr[15:0] == OFF_MSIP);
   assign sel_cmp   = (I_req_addr[15:0] == OFF_CMP);
   assign sel_mtime = (I_req_addr[15:0] == OFF_MTIME);
   assign mapped    = sel_msip | sel_cmp | sel_mtime;

   always_comb begin
      bytemask = '0;
      for (int i = 0; i < 8; i++) begin
         bytemask[8*i +: 8] = {8{I_req_wmask[i]}};
      end
   end

   always_comb begin
      state_d    = state_q;
      presc_d    = tick ? '0 : presc_q + PW'(1);
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RESP;
               err_d   = ~mapped;
               rdata_d = '0;
               if (I_req_wen) begin
                  if (sel_msip && I_req_wmask[0]) msip_d = I_req_wdata[0];
                  if (sel_cmp)   mtimecmp_d = (I_req_wdata & bytemask) | (mtimecmp_q & ~bytemask);
                  // unwritten bytes keep counting so a partial write never loses a tick
                  if (sel_mtime) mtime_d = (I_req_wdata & bytemask) | (mtime_inc & ~bytemask);
               end else begin
                  if (sel_msip)  rdata_d = {63'd0, msip_q};
                  if (sel_cmp)   rdata_d = mtimecmp_q;
                  if (sel_mtime) rdata_d = mtime_q;
               end
            end
         end
         S_RESP: begin
            if (I_resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_q    <= S_IDLE;
         presc_q    <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         mtip_q     <= 1'b0;
         msip_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         mtip_q     <= (mtime_q >= mtimecmp_q);
         msip_out_q <= msip_q;
      end
   end

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// Bench for ysyx_22040750_clint: two instances (TICK_DIV 1 and 4) share one request port and
// are checked against an arithmetic model of mtime derived from the edge count since reset.
module tb_ysyx_22040750_clint;

   localparam logic [31:0] BASE    = 32'h0200_0000;
   localparam logic [31:0] A_MSIP  = BASE;
   localparam logic [31:0] A_CMP   = BASE + 32'h4000;
   localparam logic [31:0] A_MTIME = BASE + 32'hBFF8;
   localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_wen, resp_ready;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        ready1, rv1, err1, hit1, mtip1, msip1;
   logic        ready4, rv4, err4, hit4, mtip4, msip4;
   logic [63:0] rd1, rd4;

   always #5 clk = ~clk;

   ysyx_22040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
      .I_sys_clk(clk), .I_rst(rst), .I_req_valid(req_valid), .O_req_ready(ready1),
      .I_req_wen(req_wen), .I_req_addr(req_addr), .I_req_wdata(req_wdata), .I_req_wmask(req_wmask),
      .O_resp_valid(rv1), .I_resp_ready(resp_ready), .O_resp_rdata(rd1), .O_resp_err(err1),
      .O_hit(hit1), .O_mtip(mtip1), .O_msip(msip1));

   ysyx_22040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
      .I_sys_clk(clk), .I_rst(rst), .I_req_valid(req_valid), .O_req_ready(ready4),
      .I_req_wen(req_wen), .I_req_addr(req_addr), .I_req_wdata(req_wdata), .I_req_wmask(req_wmask),
      .O_resp_valid(rv4), .I_resp_ready(resp_ready), .O_resp_rdata(rd4), .O_resp_err(err4),
      .O_hit(hit4), .O_mtip(mtip4), .O_msip(msip4));

   // cyc = number of clock edges since reset was released
   int cyc;
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // model: mtime value right after a write edge, then grows with elapsed edges / ticks
   logic [63:0] b1, b4, cmp_old, cmp_new;
   int          w1, w4, cmp_w;
   logic        msip_m;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] mt1(input int e);
      return b1 + 64'(e - w1);
   endfunction

   function automatic logic [63:0] mt4(input int e);
      return b4 + 64'((e / 4) - (w4 / 4));
   endfunction

   function automatic logic [63:0] cmpv(input int e);
      return (e >= cmp_w) ? cmp_new : cmp_old;
   endfunction

   task automatic model_reset();
      b1 = '0; w1 = 0; b4 = '0; w4 = 0;
      cmp_old = ONES; cmp_new = ONES; cmp_w = 0;
      msip_m = 1'b0;
   endtask

   task automatic model_access(input int w, input logic wen, input logic [31:0] addr,
                               input logic [63:0] wd, input logic [7:0] m,
                               output logic [63:0] e1, output logic [63:0] e4, output logic eerr);
      logic [15:0] off;
      off  = addr[15:0];
      e1   = '0;
      e4   = '0;
      eerr = !(off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8);
      if (!wen) begin
         case (off)
            16'h0000: begin e1 = {63'd0, msip_m}; e4 = e1; end
            16'h4000: begin e1 = cmpv(w - 1); e4 = e1; end
            16'hBFF8: begin e1 = mt1(w - 1); e4 = mt4(w - 1); end
            default: ;
         endcase
      end else begin
         case (off)
            16'h0000: if (m[0]) msip_m = wd[0];
            16'h4000: begin
               cmp_old = cmpv(w - 1);
               cmp_new = merge(cmp_old, wd, m);
               cmp_w   = w;
            end
            16'hBFF8: begin
               b1 = merge(mt1(w - 1) + 64'd1, wd, m);
               w1 = w;
               b4 = merge(mt4(w - 1) + ((w % 4 == 0) ? 64'd1 : 64'd0), wd, m);
               w4 = w;
            end
            default: ;
         endcase
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
      req_addr = '0; req_wdata = '0; req_wmask = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // one transaction; accept edge aligned so that (edge % 4) == align when align >= 0
   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] m, input int align, input int hold,
                         output int w, output logic v, output logic [63:0] r1, output logic [63:0] r4,
                         output logic er1, output logic er4);
      if (align >= 0)
         for (int g = 0; g < 4 && ((cyc + 1) % 4) != align; g++) @(negedge clk);
      req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = m;
      resp_ready = 1'b0;
      @(posedge clk);
      #1 w = cyc;
      @(negedge clk);
      req_valid = 1'b0; req_wen = 1'b0;
      v = rv1 && rv4; r1 = rd1; r4 = rd4; er1 = err1; er4 = err4;
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int w; logic v, e1, e4, xe; logic [63:0] r1, r4, x1, x4;
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
      req_addr = '0; req_wdata = '0; req_wmask = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rv1, rv4, err1, mtip1, msip1, ready1} !== 6'b000001 || rd1 !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rv=%b%b err=%b mtip=%b msip=%b rdy=%b rdata=%h want 000001 rdata=0",
                  rv1, rv4, err1, mtip1, msip1, ready1, rd1);
      end
      rst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      do_req(1'b0, A_MTIME, '0, '0, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, A_MTIME, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || r1 !== 64'd10 || r1 !== x1 || r4 !== x4 || e1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mtime_read: got v=%b r1=%h r4=%h err=%b want v=1 r1=%h(10) r4=%h err=0",
                  v, r1, r4, e1, x1, x4);
      end
      n_checks++;
      if (mtip1 !== 1'b0 || msip1 !== 1'b0 || mtip4 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq: got mtip=%b msip=%b mtip4=%b want 0 0 0", mtip1, msip1, mtip4);
      end
   endtask

   task automatic test_timer_compare();
      int w; logic v, e1, e4, xe, exp1, exp4; logic [63:0] r1, r4, x1, x4;
      do_reset();
      repeat (5) @(negedge clk);
      do_req(1'b1, A_CMP, 64'd20, 8'hFF, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_CMP, 64'd20, 8'hFF, x1, x4, xe);
      n_checks++;
      if (!v || r1 !== 64'd0 || e1 !== 1'b0) begin
         n_fail++;
         $display("FAIL cmp_write_resp: got v=%b rdata=%h err=%b want v=1 rdata=0 err=0", v, r1, e1);
      end
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         exp1 = (mt1(cyc - 1) >= cmpv(cyc - 1));
         exp4 = (mt4(cyc - 1) >= cmpv(cyc - 1));
         n_checks++;
         if (mtip1 !== exp1 || mtip4 !== exp4) begin
            n_fail++;
            $display("FAIL mtip_rise cyc=%0d: got %b/%b want %b/%b", cyc, mtip1, mtip4, exp1, exp4);
         end
      end
      do_req(1'b1, A_CMP, ONES, 8'hFF, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_CMP, ONES, 8'hFF, x1, x4, xe);
      n_checks++;
      if (mtip1 !== 1'b0 || mtip1 !== (mt1(cyc - 1) >= cmpv(cyc - 1))) begin
         n_fail++;
         $display("FAIL mtip_clear: got %b want 0", mtip1);
      end
   endtask

   task automatic test_wrap();
      int w; logic v, e1, e4, xe; logic [63:0] r1, r4, x1, x4;
      do_req(1'b1, A_CMP, 64'd0, 8'hFF, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_CMP, 64'd0, 8'hFF, x1, x4, xe);
      do_req(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, x1, x4, xe);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (mtip1 !== 1'b1 || mtip4 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_mtip cyc=%0d: got %b/%b want 1/1", cyc, mtip1, mtip4);
         end
         @(negedge clk);
      end
      do_req(1'b0, A_MTIME, '0, '0, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, A_MTIME, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || r1 !== x1 || r4 !== x4 || r1 > 64'd16) begin
         n_fail++;
         $display("FAIL wrap_read: got v=%b r1=%h r4=%h want r1=%h r4=%h", v, r1, r4, x1, x4);
      end
   endtask

   task automatic test_prescaler_partial_write();
      int w; logic v, e1, e4, xe; logic [63:0] r1, r4, x1, x4;
      do_reset();
      do_req(1'b1, A_MTIME, 64'h0000_0001_0000_0000, 8'hFF, 0, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_MTIME, 64'h0000_0001_0000_0000, 8'hFF, x1, x4, xe);
      do_req(1'b1, A_MTIME, 64'h0000_0000_1234_5678, 8'h0F, 0, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_MTIME, 64'h0000_0000_1234_5678, 8'h0F, x1, x4, xe);
      do_req(1'b0, A_MTIME, '0, '0, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, A_MTIME, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || r4 !== 64'h0000_0001_1234_5678 || r4 !== x4 || r1 !== x1) begin
         n_fail++;
         $display("FAIL partial_tick_write: got r4=%h r1=%h want r4=%h r1=%h", r4, r1, x4, x1);
      end
      do_req(1'b0, A_MTIME, '0, '0, 0, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, A_MTIME, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || r4 !== 64'h0000_0001_1234_5678 || r4 !== x4) begin
         n_fail++;
         $display("FAIL pre_tick_read: got r4=%h want %h", r4, x4);
      end
      do_req(1'b0, A_MTIME, '0, '0, 1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, A_MTIME, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || r4 !== x4 || r4 !== 64'h0000_0001_1234_567A) begin
         n_fail++;
         $display("FAIL post_tick_read: got r4=%h want %h", r4, x4);
      end
   endtask

   task automatic test_unmapped();
      int w; logic v, e1, e4, xe; logic [63:0] r1, r4, x1, x4;
      do_req(1'b0, BASE + 32'h8000, '0, '0, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, BASE + 32'h8000, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || e1 !== 1'b1 || e4 !== 1'b1 || r1 !== 64'd0) begin
         n_fail++;
         $display("FAIL unmapped_read: got v=%b err=%b/%b rdata=%h want v=1 err=1/1 rdata=0", v, e1, e4, r1);
      end
      do_req(1'b1, BASE + 32'h4008, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, BASE + 32'h4008, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, x1, x4, xe);
      do_req(1'b0, A_CMP, '0, '0, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b0, A_CMP, '0, '0, x1, x4, xe);
      n_checks++;
      if (!v || r1 !== x1 || e1 !== 1'b0) begin
         n_fail++;
         $display("FAIL unmapped_write_no_effect: got cmp=%h err=%b want cmp=%h err=0", r1, e1, x1);
      end
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0300_0000;
      #1;
      n_checks++;
      if (hit1 !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_hit: got %b want 0", hit1);
      end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (rv1 !== 1'b0 || ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_ignored: got rv=%b rdy=%b want 0 1", rv1, ready1);
         end
      end
      req_valid = 1'b0;
      req_addr = BASE + 32'h0000_1230;
      #1;
      n_checks++;
      if (hit1 !== 1'b1) begin
         n_fail++;
         $display("FAIL base_hit: got %b want 1", hit1);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int w; logic v, e1, e4, xe; logic [63:0] r1, r4, x1, x4;
      do_req(1'b1, A_MSIP, 64'h0000_0000_FFFF_FFFF, 8'h01, -1, 0, w, v, r1, r4, e1, e4);
      model_access(w, 1'b1, A_MSIP, 64'h0000_0000_FFFF_FFFF, 8'h01, x1, x4, xe);
      n_checks++;
      if (msip1 !== 1'b1) begin
         n_fail++;
         $display("FAIL msip_set: got %b want 1", msip1);
      end
      req_valid = 1'b1; req_wen = 1'b0; req_addr = A_MSIP; resp_ready = 1'b0;
      @(posedge clk);
      #1 w = cyc;
      model_access(w, 1'b0, A_MSIP, '0, '0, x1, x4, xe);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rv1 !== 1'b1 || rd1 !== x1 || rd1 !== 64'd1 || ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_resp %0d: got rv=%b rdata=%h rdy=%b want 1 %h 0", i, rv1, rd1, ready1, x1);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      n_checks++;
      if (rv1 !== 1'b0 || ready1 !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_release: got rv=%b rdy=%b want 0 1", rv1, ready1);
      end
   endtask

   task automatic test_reset_in_resp();
      req_valid = 1'b1; req_wen = 1'b0; req_addr = A_MSIP; resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if (rv1 !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_resp: got rv=%b want 1", rv1);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rv1 !== 1'b0 || rv4 !== 1'b0 || rd1 !== 64'd0 || msip1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_resp: got rv=%b/%b rdata=%h msip=%b want 0/0 0 0", rv1, rv4, rd1, msip1);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      int w, sel, hold; logic v, e1, e4, xe, wen, exp1, exp4;
      logic [63:0] r1, r4, x1, x4, wd; logic [31:0] addr; logic [7:0] m;
      for (int i = 0; i < 40; i++) begin
         sel  = $urandom_range(0, 3);
         addr = (sel == 0) ? A_MSIP : (sel == 1) ? A_CMP : (sel == 2) ? A_MTIME : BASE + 32'h0008;
         wen  = 1'($urandom_range(0, 1));
         wd   = {$urandom, $urandom};
         m    = 8'($urandom);
         hold = $urandom_range(0, 2);
         do_req(wen, addr, wd, m, -1, hold, w, v, r1, r4, e1, e4);
         model_access(w, wen, addr, wd, m, x1, x4, xe);
         n_checks++;
         if (!v || r1 !== x1 || r4 !== x4 || e1 !== xe || e4 !== xe) begin
            n_fail++;
            $display("FAIL rand_resp %0d: got v=%b r1=%h r4=%h err=%b%b want r1=%h r4=%h err=%b",
                     i, v, r1, r4, e1, e4, x1, x4, xe);
         end
         exp1 = (mt1(cyc - 1) >= cmpv(cyc - 1));
         exp4 = (mt4(cyc - 1) >= cmpv(cyc - 1));
         n_checks++;
         if (mtip1 !== exp1 || mtip4 !== exp4 || msip1 !== msip_m || msip4 !== msip_m) begin
            n_fail++;
            $display("FAIL rand_irq %0d: got mtip=%b/%b msip=%b/%b want %b/%b %b",
                     i, mtip1, mtip4, msip1, msip4, exp1, exp4, msip_m);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_timer_compare();
      test_wrap();
      test_prescaler_partial_write();
      test_unmapped();
      test_backpressure();
      test_reset_in_resp();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
